// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT pipeline: stage sequencing states
// and the constant functions used to size per-stage counters.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sdf_state_e;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Delay-line length (half block) of a given stage.
  function automatic int half_len(input int n, input int stage);
    return n >> (stage + 1);
  endfunction

endpackage

// File: rtl/strobe_delay.sv
// Fixed-latency shift register for a bundle of single-cycle strobes, used to
// line control pulses up with a datapath pipeline of DEPTH register stages.
module strobe_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: block position counter, fill /
// butterfly steering, twiddle addressing and latency-matched output strobes.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGE  = 0,
  parameter int BF_LAT = 2,
  parameter int AW     = $clog2(N) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          flush,
  output logic          bf_en,
  output logic          dl_shift,
  output logic [AW-1:0] tw_addr,
  output logic          out_valid,
  output logic          out_sof,
  output logic          busy,
  output logic          sof_err
);

  localparam int L  = half_len(N, STAGE);
  localparam int CW = clog2(2 * L);

  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_HALF      = CW'(L);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(L - 1);
  localparam logic [CW-1:0] LOW_MASK      = CW'(L - 1);
  localparam bit            SINGLE        = (L == 1);

  sdf_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          flush_pend, flush_pend_nxt;
  logic          sof_pend, sof_pend_nxt;
  logic          sof_err_q, sof_err_nxt;
  logic          strobe;
  logic          produce;
  logic          produce_sof;
  logic          start;
  logic          flush_req;
  logic [CW-1:0] cnt_low;

  // Strobe semantics: no backpressure. A sample is taken on every cycle the
  // strobe is high; in_sof only has meaning together with in_valid.
  assign start     = in_valid & in_sof;
  assign flush_req = flush | flush_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      sof_pend   <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flush_pend <= flush_pend_nxt;
      sof_pend   <= sof_pend_nxt;
      sof_err_q  <= sof_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    flush_pend_nxt = flush_pend;
    sof_pend_nxt   = sof_pend;
    sof_err_nxt    = sof_err_q;
    strobe         = 1'b0;
    produce        = 1'b0;
    produce_sof    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          strobe       = 1'b1;
          cnt_nxt      = CNT_ONE;
          sof_pend_nxt = 1'b1;
          state_nxt    = SINGLE ? RUN : FILL;
        end
      end

      FILL: begin
        if (in_valid) begin
          strobe  = 1'b1;
          cnt_nxt = cnt + CNT_ONE;
          if (cnt == CNT_HALF_LAST) state_nxt = RUN;
        end
      end

      RUN: begin
        if (start) begin
          // A frame start always wins over a flush request.
          strobe         = 1'b1;
          cnt_nxt        = CNT_ONE;
          sof_pend_nxt   = 1'b1;
          flush_pend_nxt = 1'b0;
          if (cnt != '0) begin
            sof_err_nxt = 1'b1;
            state_nxt   = SINGLE ? RUN : FILL;
          end else begin
            produce = 1'b1;
          end
        end else if ((cnt == '0) && flush_req) begin
          flush_pend_nxt = 1'b0;
          state_nxt      = FLUSH;
        end else begin
          if (flush) flush_pend_nxt = 1'b1;
          if (in_valid) begin
            strobe  = 1'b1;
            produce = 1'b1;
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end

      FLUSH: begin
        // Drain the delay line with internal strobes; input samples are lost.
        strobe  = 1'b1;
        produce = 1'b1;
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // The first butterfly output of a frame leaves at position L of its first block.
    produce_sof = produce & sof_pend & (cnt == CNT_HALF);
    if (produce_sof) sof_pend_nxt = 1'b0;
  end

  assign cnt_low  = cnt & LOW_MASK;
  assign bf_en    = cnt[CW-1];
  assign tw_addr  = AW'(cnt_low) << STAGE;
  assign dl_shift = strobe;
  assign busy     = (state != IDLE);
  assign sof_err  = sof_err_q;

  strobe_delay #(
    .DEPTH (BF_LAT),
    .W     (2)
  ) u_strobe_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({produce_sof, produce}),
    .dout ({out_sof, out_valid})
  );

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Bench for fft_sdf_stage_ctrl: an L=4 stage and an L=1 stage share one input
// stream and are compared every cycle against a sample-position reference model.
module tb_fft_sdf_stage_ctrl;

  localparam int N      = 16;
  localparam int BF_LAT = 2;
  localparam int AW     = 3;
  localparam int HMAX   = 4096;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_sof;
  logic flush;

  logic          a_bf_en, a_dl_shift, a_out_valid, a_out_sof, a_busy, a_sof_err;
  logic [AW-1:0] a_tw_addr;
  logic          b_bf_en, b_dl_shift, b_out_valid, b_out_sof, b_busy, b_sof_err;
  logic [AW-1:0] b_tw_addr;

  int n_assert;
  int n_fail;
  int cyc;

  // Reference model, index 0 = STAGE 1 (L=4), index 1 = STAGE 3 (L=1).
  // mode: 0 waiting for frame, 1 first half of first frame, 2 streaming, 3 draining
  int m_mode [2];
  int m_pos  [2];
  bit m_err  [2];
  bit m_pend [2];
  bit m_sofp [2];
  bit ps_now [2];
  bit hist_v [2][HMAX];
  bit hist_s [2][HMAX];

  fft_sdf_stage_ctrl #(.N(N), .STAGE(1), .BF_LAT(BF_LAT)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .flush(flush),
    .bf_en(a_bf_en), .dl_shift(a_dl_shift), .tw_addr(a_tw_addr),
    .out_valid(a_out_valid), .out_sof(a_out_sof), .busy(a_busy), .sof_err(a_sof_err)
  );

  fft_sdf_stage_ctrl #(.N(N), .STAGE(3), .BF_LAT(BF_LAT)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .flush(flush),
    .bf_en(b_bf_en), .dl_shift(b_dl_shift), .tw_addr(b_tw_addr),
    .out_valid(b_out_valid), .out_sof(b_out_sof), .busy(b_busy), .sof_err(b_sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int half_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int stage_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_eval(input int k, input bit v, input bit s, input bit f,
                            output bit st, output bit pr, output bit ps);
    st = 1'b0;
    pr = 1'b0;
    case (m_mode[k])
      0: st = v && s;
      1: st = v;
      2: begin
        if (v && s) begin
          st = 1'b1;
          pr = (m_pos[k] == 0);
        end else if (m_pos[k] == 0 && (f || m_pend[k])) begin
          st = 1'b0;
        end else begin
          st = v;
          pr = v;
        end
      end
      default: begin
        st = 1'b1;
        pr = 1'b1;
      end
    endcase
    ps = pr && m_sofp[k] && (m_pos[k] == half_of(k));
  endtask

  task automatic model_update(input int k, input bit v, input bit s, input bit f,
                              input bit r, input bit ps);
    int hl;
    hl = half_of(k);
    if (r) begin
      m_mode[k] = 0;
      m_pos[k]  = 0;
      m_err[k]  = 1'b0;
      m_pend[k] = 1'b0;
      m_sofp[k] = 1'b0;
      for (int t = cyc - 4; t <= cyc; t++) begin
        if (t >= 0) begin
          hist_v[k][t] = 1'b0;
          hist_s[k][t] = 1'b0;
        end
      end
      return;
    end
    if (ps) m_sofp[k] = 1'b0;
    case (m_mode[k])
      0: begin
        if (v && s) begin
          m_pos[k]  = 1;
          m_sofp[k] = 1'b1;
          m_mode[k] = (hl == 1) ? 2 : 1;
        end
      end
      1: begin
        if (v) begin
          m_pos[k]++;
          if (m_pos[k] == hl) m_mode[k] = 2;
        end
      end
      2: begin
        if (v && s) begin
          if (m_pos[k] != 0) begin
            m_err[k]  = 1'b1;
            m_mode[k] = (hl == 1) ? 2 : 1;
          end
          m_pos[k]  = 1;
          m_sofp[k] = 1'b1;
          m_pend[k] = 1'b0;
        end else if (m_pos[k] == 0 && (f || m_pend[k])) begin
          m_mode[k] = 3;
          m_pend[k] = 1'b0;
        end else begin
          if (f) m_pend[k] = 1'b1;
          if (v) m_pos[k] = (m_pos[k] + 1) % (2 * hl);
        end
      end
      default: begin
        m_pos[k]++;
        if (m_pos[k] == hl) begin
          m_mode[k] = 0;
          m_pos[k]  = 0;
        end
      end
    endcase
  endtask

  task automatic check_inst(input int k, input bit exp_st);
    string  nm;
    logic   o_bf, o_dl, o_ov, o_os, o_busy, o_err;
    logic [AW-1:0] o_tw;
    bit     e_ov, e_os;
    int     hl;
    hl = half_of(k);
    if (k == 0) begin
      nm = "s1"; o_bf = a_bf_en; o_dl = a_dl_shift; o_tw = a_tw_addr;
      o_ov = a_out_valid; o_os = a_out_sof; o_busy = a_busy; o_err = a_sof_err;
    end else begin
      nm = "s3"; o_bf = b_bf_en; o_dl = b_dl_shift; o_tw = b_tw_addr;
      o_ov = b_out_valid; o_os = b_out_sof; o_busy = b_busy; o_err = b_sof_err;
    end
    e_ov = (cyc >= BF_LAT) ? hist_v[k][cyc - BF_LAT] : 1'b0;
    e_os = (cyc >= BF_LAT) ? hist_s[k][cyc - BF_LAT] : 1'b0;
    chk({nm, ".dl_shift"},  8'(o_dl),   8'(exp_st));
    chk({nm, ".bf_en"},     8'(o_bf),   8'(m_pos[k] >= hl));
    chk({nm, ".tw_addr"},   8'(o_tw),   8'((m_pos[k] % hl) << stage_of(k)));
    chk({nm, ".out_valid"}, 8'(o_ov),   8'(e_ov));
    chk({nm, ".out_sof"},   8'(o_os),   8'(e_os));
    chk({nm, ".busy"},      8'(o_busy), 8'(m_mode[k] != 0));
    chk({nm, ".sof_err"},   8'(o_err),  8'(m_err[k]));
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model past the edge.
  task automatic tick(input bit v, input bit s, input bit f, input bit r);
    bit st, pr, ps;
    in_valid = v;
    in_sof   = s;
    flush    = f;
    rst      = r;
    #3;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, v, s, f, st, pr, ps);
      check_inst(k, st);
      hist_v[k][cyc] = pr;
      hist_s[k][cyc] = ps;
      ps_now[k] = ps;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_update(k, v, s, f, r, ps_now[k]);
    cyc++;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pos[k] = 0; m_err[k] = 1'b0;
      m_pend[k] = 1'b0; m_sofp[k] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then samples without a frame start are ignored; flush in IDLE too.
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);

    // Two gapless frames with an in-place frame start at sample 16.
    for (int i = 0; i < 32; i++) tick(1, (i == 0 || i == 16), 0, 0);

    // Gapped input: alternate on/off with occasional longer pauses.
    for (int i = 0; i < 24; i++) begin
      tick(1, 0, 0, 0);
      repeat ($urandom_range(1, 2)) tick(0, 0, 0, 0);
    end

    // Reset mid-stream, then activity without a frame start produces nothing.
    tick(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);

    // New frame, then a misplaced frame start at position 3 of the streaming phase.
    tick(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) tick(1, 0, 0, 0);

    // Flush requested at position 5, deferred to the wrap, then drained.
    tick(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);

    // Frame start together with flush at a block boundary: the frame start wins.
    tick(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) tick(1, 0, 0, 0);
    tick(1, 1, 1, 0);
    for (int i = 0; i < 9; i++) tick(1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
